// File: rtl/ts4231_config_reader.sv
// TS4231 configuration readback: replays the D/E bit-bang handshake and
// clocks the sensor's 15-bit configuration word in MSB first on E high.
module ts4231_config_reader #(
  parameter int                  CLK_DIV      = 24,
  parameter int                  CFG_BITS     = 15,
  parameter logic [CFG_BITS-1:0] EXPECTED_CFG = 15'h392B
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [CFG_BITS-1:0] config_word,
  output logic                match,
  input  logic                d_in,
  output logic                d_out,
  output logic                d_oe,
  input  logic                e_in,
  output logic                e_out,
  output logic                e_oe
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_PRE         = 4'd1,
    ST_D_LOW       = 4'd2,
    ST_E_LOW       = 4'd3,
    ST_D_REL       = 4'd4,
    ST_BIT_E_HIGH  = 4'd5,
    ST_BIT_E_LOW   = 4'd6,
    ST_STOP_D_LOW  = 4'd7,
    ST_STOP_E_HIGH = 4'd8,
    ST_STOP_D_HIGH = 4'd9
  } state_t;

  state_t              state_r;
  state_t              succ_s;
  state_t              next_state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                tick_s;
  logic                start_prev_r;
  logic                start_edge_s;
  logic                pending_r;
  logic [IDX_W-1:0]    bit_idx_r;
  logic [CFG_BITS-1:0] shift_r;
  logic [CFG_BITS-1:0] config_word_r;
  logic                match_r;
  logic                busy_r;
  logic                done_r;
  logic                e_in_unused_s;

  assign e_in_unused_s = e_in;
  assign tick_s        = (cnt_r == CNT_W'(CLK_DIV - 1));
  assign start_edge_s  = start & ~start_prev_r;

  assign busy        = busy_r;
  assign done        = done_r;
  assign config_word = config_word_r;
  assign match       = match_r;

  // Free-running protocol tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Start edge detect; previous value resets high so a level held through reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_r <= 1'b1;
    end else begin
      start_prev_r <= start;
    end
  end

  // Pending request: armed only while idle, consumed by the launching tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else if (state_r == ST_IDLE && tick_s && pending_r) begin
      pending_r <= 1'b0;
    end else if (state_r == ST_IDLE && start_edge_s) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Successor state and pad drive; the sensor owns D throughout the bit states
  always_comb begin
    succ_s = state_r;
    d_out  = 1'b0;
    d_oe   = 1'b0;
    e_out  = 1'b1;
    e_oe   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r) begin
          succ_s = ST_PRE;
        end else begin
          succ_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        succ_s = ST_D_LOW;
        d_out = 1'b1; d_oe = 1'b1; e_out = 1'b1; e_oe = 1'b1;
      end
      ST_D_LOW: begin
        succ_s = ST_E_LOW;
        d_out = 1'b0; d_oe = 1'b1; e_out = 1'b1; e_oe = 1'b1;
      end
      ST_E_LOW: begin
        succ_s = ST_D_REL;
        d_out = 1'b0; d_oe = 1'b1; e_out = 1'b0; e_oe = 1'b1;
      end
      ST_D_REL: begin
        succ_s = ST_BIT_E_HIGH;
        e_out = 1'b0; e_oe = 1'b1;
      end
      ST_BIT_E_HIGH: begin
        succ_s = ST_BIT_E_LOW;
        e_out = 1'b1; e_oe = 1'b1;
      end
      ST_BIT_E_LOW: begin
        if (bit_idx_r == '0) begin
          succ_s = ST_STOP_D_LOW;
        end else begin
          succ_s = ST_BIT_E_HIGH;
        end
        e_out = 1'b0; e_oe = 1'b1;
      end
      ST_STOP_D_LOW: begin
        succ_s = ST_STOP_E_HIGH;
        d_out = 1'b0; d_oe = 1'b1; e_out = 1'b0; e_oe = 1'b1;
      end
      ST_STOP_E_HIGH: begin
        succ_s = ST_STOP_D_HIGH;
        d_out = 1'b0; d_oe = 1'b1; e_out = 1'b1; e_oe = 1'b1;
      end
      ST_STOP_D_HIGH: begin
        succ_s = ST_IDLE;
        d_out = 1'b1; d_oe = 1'b1; e_out = 1'b1; e_oe = 1'b1;
      end
      default: begin
        succ_s = ST_IDLE;
      end
    endcase
    if (tick_s) begin
      next_state_s = succ_s;
    end else begin
      next_state_s = state_r;
    end
  end

  // Sequence datapath: bit counter, shift register, result and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_r     <= '0;
      shift_r       <= '0;
      config_word_r <= '0;
      match_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            if (pending_r) begin
              busy_r <= 1'b1;
            end else begin
              busy_r <= 1'b0;
            end
          end
          ST_D_REL: begin
            bit_idx_r <= IDX_W'(CFG_BITS - 1);
          end
          ST_BIT_E_HIGH: begin
            shift_r <= {shift_r[CFG_BITS-2:0], d_in};
          end
          ST_BIT_E_LOW: begin
            if (bit_idx_r != '0) begin
              bit_idx_r <= bit_idx_r - IDX_W'(1);
            end else begin
              bit_idx_r <= bit_idx_r;
            end
          end
          ST_STOP_D_HIGH: begin
            config_word_r <= shift_r;
            match_r       <= (shift_r == EXPECTED_CFG);
            done_r        <= 1'b1;
            busy_r        <= 1'b0;
          end
          default: begin
            bit_idx_r <= bit_idx_r;
          end
        endcase
      end else begin
        bit_idx_r <= bit_idx_r;
      end
    end
  end

endmodule

// File: tb/tb_ts4231_config_reader.sv
// Self-checking bench: a sensor model answers the readback on E rising edges,
// a pad monitor tracks start/stop conditions and D ownership.
module tb_ts4231_config_reader;

  localparam int          CLK_DIV    = 24;
  localparam int          CFG_BITS   = 15;
  localparam logic [14:0] EXP_CFG    = 15'h392B;
  localparam int          READ_TICKS = 4 + 2 * CFG_BITS + 3;
  localparam int          READ_CLKS  = READ_TICKS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [14:0] config_word;
  logic        match;
  logic        d_in = 1'b0;
  logic        d_out;
  logic        d_oe;
  logic        e_in;
  logic        e_out;
  logic        e_oe;

  int checks = 0;
  int errors = 0;

  ts4231_config_reader #(.CLK_DIV(CLK_DIV), .CFG_BITS(CFG_BITS), .EXPECTED_CFG(EXP_CFG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .config_word(config_word), .match(match), .d_in(d_in), .d_out(d_out),
    .d_oe(d_oe), .e_in(e_in), .e_out(e_out), .e_oe(e_oe)
  );

  always #5 clk = ~clk;

  // Sensor model and pad monitor state
  logic [14:0] sensor_word = 15'h0;
  logic        p_d_oe = 1'b0, p_d_out = 1'b0, p_e_oe = 1'b0, p_e_out = 1'b1;
  int          start_cnt = 0, stop_cnt = 0, tog_cnt = 0, viol_cnt = 0, done_cnt = 0, bit_k = 0;

  always @(posedge clk) begin
    if (p_d_oe && p_d_out && d_oe && !d_out && p_e_oe && p_e_out && e_oe && e_out) begin
      start_cnt <= start_cnt + 1;
      tog_cnt   <= 0;
      bit_k     <= 0;
    end else if (!rst_n) begin
      tog_cnt <= 0;
    end else if (p_e_oe && e_oe && !p_d_oe && !d_oe && (p_e_out != e_out)) begin
      tog_cnt <= tog_cnt + 1;
      if (e_out && bit_k < CFG_BITS) begin
        d_in  <= sensor_word[CFG_BITS-1-bit_k];
        bit_k <= bit_k + 1;
      end
    end
    if (p_d_oe && !p_d_out && d_oe && d_out && p_e_oe && p_e_out && e_oe && e_out)
      stop_cnt <= stop_cnt + 1;
    if (d_oe && tog_cnt > 0 && tog_cnt < 2 * CFG_BITS)
      viol_cnt <= viol_cnt + 1;
    if (done)
      done_cnt <= done_cnt + 1;
    p_d_oe  <= d_oe;
    p_d_out <= d_out;
    p_e_oe  <= e_oe;
    p_e_out <= e_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [14:0] prev_word  = 15'h0;
  logic        prev_match = 1'b0;

  task automatic run_read(input logic [14:0] w, input bit repulse);
    int n;
    bit dropped;
    int b_start, b_stop, b_viol, b_done;
    b_start = start_cnt; b_stop = stop_cnt; b_viol = viol_cnt; b_done = done_cnt;
    sensor_word = w;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!busy && n < 3 * CLK_DIV) begin
      @(negedge clk); n++;
    end
    chk("launch_latency", 32'((n >= 1) && (n <= CLK_DIV)), 32'd1);
    chk("held_word", 32'(config_word), 32'(prev_word));
    chk("held_match", 32'(match), 32'(prev_match));
    n = 0;
    dropped = 1'b0;
    while (!done && n < READ_CLKS + 100) begin
      @(negedge clk); n++;
      if (repulse && n == 10 * CLK_DIV) start = 1'b1;
      if (repulse && n == 10 * CLK_DIV + 2) start = 1'b0;
      if (!busy && !done) dropped = 1'b1;
    end
    chk("done_latency", 32'(n), 32'(READ_CLKS));
    chk("config_word", 32'(config_word), 32'(w));
    chk("match", 32'(match), 32'(w == EXP_CFG));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("busy_held", 32'(dropped), 32'd0);
    chk("start_cond_once", 32'(start_cnt - b_start), 32'd1);
    chk("stop_cond_once", 32'(stop_cnt - b_stop), 32'd1);
    chk("released_e_toggles", 32'(tog_cnt), 32'(2 * CFG_BITS));
    chk("d_driven_in_bits", 32'(viol_cnt - b_viol), 32'd0);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    repeat (3 * CLK_DIV) @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("single_done", 32'(done_cnt - b_done), 32'd1);
    prev_word  = w;
    prev_match = (w == EXP_CFG);
  endtask

  initial begin
    int n;
    logic [14:0] w;
    rst_n = 1'b0; start = 1'b0; e_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_word", 32'(config_word), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_pads", 32'({d_oe, e_oe, d_out, e_out}), 32'b0001);
    rst_n = 1'b1;

    // Tick period and idle pads with start held low
    n = 0;
    while (!dut.tick_s && n < 3 * CLK_DIV) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    n = 1;
    while (!dut.tick_s && n < 3 * CLK_DIV) begin
      @(negedge clk); n++;
    end
    chk("tick_period", 32'(n), 32'(CLK_DIV));
    repeat (5 * CLK_DIV) @(negedge clk);
    chk("idle_pads", 32'({d_oe, e_oe, e_out}), 32'b001);
    chk("idle_busy", 32'(busy), 32'd0);

    run_read(15'h392B, 1'b0);
    run_read(15'h392A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w = 15'($urandom);
      run_read(w, 1'b0);
    end
    run_read(15'($urandom), 1'b1);

    // Reset in the middle of the bit phase
    sensor_word = 15'($urandom);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (bit_k != 8 && n < 2 * READ_CLKS) begin
      @(negedge clk); n++;
    end
    chk("reached_bit7", 32'(bit_k), 32'd8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pads", 32'({d_oe, e_oe}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_word", 32'(config_word), 32'd0);
    chk("midrst_match", 32'(match), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk);
    chk("midrst_no_relaunch", 32'(busy), 32'd0);
    prev_word  = 15'h0;
    prev_match = 1'b0;
    run_read(15'($urandom), 1'b0);

    // start held high across reset release is not an edge
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk);
    chk("start_level_at_release", 32'(busy), 32'd0);
    start = 1'b0;
    prev_word  = 15'h0;
    prev_match = 1'b0;
    repeat (2) @(negedge clk);
    run_read(15'h392B, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
